// File: rtl/xy_scan_mux.sv
// xy_scan_mux: time-multiplexes the border trace, both paddles and the ball onto one XY DAC pair.
// Latency: all outputs registered; border points reach x_out/y_out one clk after they are presented.
// Backpressure: none; free-running scan, so the border source must supply a new point every clk.
// Option: define XY_SCAN_BALL_CROSS_EN to draw the ball as a five-point cross instead of a single dot.
module xy_scan_mux #(
    parameter int BORDER_CYCLES = 950,
    parameter int PADDLE_LEN    = 32,
    parameter int PADDLE_L_X    = 8,
    parameter int PADDLE_R_X    = 247,
    parameter int BALL_CYCLES   = 64,
    parameter int SETTLE        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x_border,
    input  logic [7:0] y_border,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [7:0] paddle_l_y,
    input  logic [7:0] paddle_r_y,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic       blank,
    output logic [1:0] src,
    output logic       frame_tick
);

    // One shared counter times settle and the fixed-length draw phases, so it
    // must be wide enough for the longest of them (normally the border trace).
    localparam int MAX_AB  = (BORDER_CYCLES > BALL_CYCLES) ? BORDER_CYCLES : BALL_CYCLES;
    localparam int MAX_CNT = (MAX_AB > SETTLE) ? MAX_AB : SETTLE;
    localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] BORDER_LAST = CW'(BORDER_CYCLES - 1);
    localparam logic [CW-1:0] BALL_LAST   = CW'(BALL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [8:0]    PAD_SPAN    = 9'(PADDLE_LEN - 1);
    localparam logic [7:0]    PL_X        = 8'(PADDLE_L_X);
    localparam logic [7:0]    PR_X        = 8'(PADDLE_R_X);

    typedef enum logic [1:0] {
        S_BORDER = 2'd0,
        S_PAD_L  = 2'd1,
        S_PAD_R  = 2'd2,
        S_BALL   = 2'd3
    } state_t;

    // Position of the cycle currently on the outputs.
    state_t        state;
    logic          draw;      // 0 = settle (beam off), 1 = draw
    logic [CW-1:0] cnt;
    logic          run;       // cleared by reset: next edge starts a fresh frame

    // Values captured when a source is entered; held for the rest of the frame.
    logic [7:0]    pad_end;
    logic [7:0]    ball_xl;
    logic [7:0]    ball_yl;

    state_t        nxt_state;
    logic          nxt_draw;
    logic [CW-1:0] nxt_cnt;
    logic          enter;

    logic [7:0]    x_d;
    logic [7:0]    y_d;
    logic          blank_d;
    logic [1:0]    src_d;
    logic          tick_d;
    logic [7:0]    pad_end_d;
    logic [7:0]    ball_xl_d;
    logic [7:0]    ball_yl_d;

`ifdef XY_SCAN_BALL_CROSS_EN
    logic [2:0]    pidx;
    logic [2:0]    pidx_d;

    function automatic logic [7:0] sat_inc2(input logic [7:0] v);
        return (v > 8'd253) ? 8'd255 : v + 8'd2;
    endfunction

    function automatic logic [7:0] sat_dec2(input logic [7:0] v);
        return (v < 8'd2) ? 8'd0 : v - 8'd2;
    endfunction
`endif

    // Top of a paddle: 9-bit sum so a paddle near the screen edge clips at 255
    // instead of wrapping to the bottom.
    function automatic logic [7:0] pad_top(input logic [7:0] y);
        logic [8:0] s;
        s = {1'b0, y} + PAD_SPAN;
        return s[8] ? 8'd255 : s[7:0];
    endfunction

    // State register: scan position, entry captures and registered DAC outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BORDER;
            draw       <= 1'b0;
            cnt        <= '0;
            run        <= 1'b0;
            pad_end    <= 8'd0;
            ball_xl    <= 8'd0;
            ball_yl    <= 8'd0;
            x_out      <= 8'd0;
            y_out      <= 8'd0;
            blank      <= 1'b1;
            src        <= 2'd0;
            frame_tick <= 1'b0;
`ifdef XY_SCAN_BALL_CROSS_EN
            pidx       <= 3'd0;
`endif
        end else begin
            state      <= nxt_state;
            draw       <= nxt_draw;
            cnt        <= nxt_cnt;
            run        <= 1'b1;
            pad_end    <= pad_end_d;
            ball_xl    <= ball_xl_d;
            ball_yl    <= ball_yl_d;
            x_out      <= x_d;
            y_out      <= y_d;
            blank      <= blank_d;
            src        <= src_d;
            frame_tick <= tick_d;
`ifdef XY_SCAN_BALL_CROSS_EN
            pidx       <= pidx_d;
`endif
        end
    end

    // Next-state logic: settle countdown, then a draw phase ended by its length
    // (border, ball) or by reaching the paddle top (paddles).
    always_comb begin
        nxt_state = state;
        nxt_draw  = draw;
        nxt_cnt   = cnt + CNT_ONE;
        if (!run) begin
            nxt_state = S_BORDER;
            nxt_draw  = 1'b0;
            nxt_cnt   = '0;
        end else if (!draw) begin
            if (cnt == SETTLE_LAST) begin
                nxt_draw = 1'b1;
                nxt_cnt  = '0;
            end
        end else begin
            case (state)
                S_BORDER: begin
                    if (cnt == BORDER_LAST) begin
                        nxt_state = S_PAD_L;
                        nxt_draw  = 1'b0;
                        nxt_cnt   = '0;
                    end
                end
                S_PAD_L: begin
                    nxt_cnt = '0;
                    if (y_out == pad_end) begin
                        nxt_state = S_PAD_R;
                        nxt_draw  = 1'b0;
                    end
                end
                S_PAD_R: begin
                    nxt_cnt = '0;
                    if (y_out == pad_end) begin
                        nxt_state = S_BALL;
                        nxt_draw  = 1'b0;
                    end
                end
                default: begin
                    if (cnt == BALL_LAST) begin
                        nxt_state = S_BORDER;
                        nxt_draw  = 1'b0;
                        nxt_cnt   = '0;
                    end
                end
            endcase
        end
    end

    // First settle cycle of a source: either the frame restart after reset or
    // the step out of the previous source's draw phase.
    assign enter = ~run | (draw & ~nxt_draw);

    // Output logic: coordinates for the upcoming cycle, plus the entry captures.
    always_comb begin
        x_d       = x_out;
        y_d       = y_out;
        blank_d   = ~nxt_draw;
        src_d     = nxt_state;
        tick_d    = enter && (nxt_state == S_BORDER);
        pad_end_d = pad_end;
        ball_xl_d = ball_xl;
        ball_yl_d = ball_yl;
`ifdef XY_SCAN_BALL_CROSS_EN
        pidx_d    = pidx;
`endif
        case (nxt_state)
            S_BORDER: begin
                // Settle holds the point seen at entry; draw follows the trace.
                if (enter || nxt_draw) begin
                    x_d = x_border;
                    y_d = y_border;
                end
            end
            S_PAD_L: begin
                if (enter) begin
                    x_d       = PL_X;
                    y_d       = paddle_l_y;
                    pad_end_d = pad_top(paddle_l_y);
                end else if (draw) begin
                    y_d = y_out + 8'd1;
                end
            end
            S_PAD_R: begin
                if (enter) begin
                    x_d       = PR_X;
                    y_d       = paddle_r_y;
                    pad_end_d = pad_top(paddle_r_y);
                end else if (draw) begin
                    y_d = y_out + 8'd1;
                end
            end
            default: begin
                if (enter) begin
                    ball_xl_d = ball_x;
                    ball_yl_d = ball_y;
                    x_d       = ball_x;
                    y_d       = ball_y;
`ifdef XY_SCAN_BALL_CROSS_EN
                    pidx_d    = 3'd0;
`endif
                end else if (nxt_draw) begin
`ifdef XY_SCAN_BALL_CROSS_EN
                    // Centre, right, left, up, down; each arm clipped at the screen edge.
                    x_d = ball_xl;
                    y_d = ball_yl;
                    case (pidx)
                        3'd1:    x_d = sat_inc2(ball_xl);
                        3'd2:    x_d = sat_dec2(ball_xl);
                        3'd3:    y_d = sat_inc2(ball_yl);
                        3'd4:    y_d = sat_dec2(ball_yl);
                        default: ;
                    endcase
                    pidx_d = (pidx == 3'd4) ? 3'd0 : pidx + 3'd1;
`else
                    x_d = ball_xl;
                    y_d = ball_yl;
`endif
                end
            end
        endcase
    end

endmodule

// File: tb/tb_xy_scan_mux.sv
module tb_xy_scan_mux;

    localparam int SETTLE_N = 4;
    localparam int BORDER_N = 950;
    localparam int BALL_N   = 64;
    localparam int FRAME    = 4 * SETTLE_N + BORDER_N + 32 + 16 + BALL_N;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_border, y_border, ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [7:0] x_out, y_out;
    logic       blank;
    logic [1:0] src;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick = -1;
    int prev_tick = -1;

    // Scoreboard of border points: pushed when driven, popped once the DUT has sampled them.
    logic [15:0] sb[$];
    logic [15:0] exp_b;

    always #5 clk = ~clk;

    xy_scan_mux dut (
        .clk        (clk),
        .rst        (rst),
        .x_border   (x_border),
        .y_border   (y_border),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .x_out      (x_out),
        .y_out      (y_out),
        .blank      (blank),
        .src        (src),
        .frame_tick (frame_tick)
    );

    // Advance one clock, sample just after the edge, then drive the next border point.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_tick === 1'b1) begin
            prev_tick = last_tick;
            last_tick = cyc;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
            exp_b = 16'h0;
        end else begin
            exp_b = sb.pop_front();
        end
        x_border = 8'($urandom_range(0, 255));
        y_border = 8'($urandom_range(0, 255));
        sb.push_back({x_border, y_border});
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ball_x     = 8'd50;
        ball_y     = 8'd60;
        paddle_l_y = 8'd100;
        paddle_r_y = 8'd240;
        x_border   = 8'h11;
        y_border   = 8'h22;
        sb.push_back({x_border, y_border});
        #3;
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", {src, blank, frame_tick, x_out, y_out},
                     {2'd0, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        repeat (3) tick();
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", {src, blank, frame_tick, x_out, y_out},
                     {2'd0, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({src, blank, frame_tick} !== {2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_frame_tick got=%b exp=%b", {src, blank, frame_tick}, {2'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_border();
        for (int i = 1; i < SETTLE_N; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick} !== {2'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL border_settle i=%0d got=%b exp=%b", i, {src, blank, frame_tick}, {2'd0, 1'b1, 1'b0});
            end
        end
        for (int i = 0; i < BORDER_N; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd0, 1'b0, 1'b0, exp_b}) begin
                errors++;
                $display("FAIL border_draw i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd0, 1'b0, 1'b0, exp_b});
            end
        end
    endtask

    task automatic test_pad_l();
        for (int i = 0; i < SETTLE_N; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd1, 1'b1, 1'b0, 8'd8, 8'd100}) begin
                errors++;
                $display("FAIL pad_l_settle i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd1, 1'b1, 1'b0, 8'd8, 8'd100});
            end
            paddle_l_y = 8'd5;
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd1, 1'b0, 1'b0, 8'd8, 8'(100 + i)}) begin
                errors++;
                $display("FAIL pad_l_draw i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd1, 1'b0, 1'b0, 8'd8, 8'(100 + i)});
            end
        end
    endtask

    task automatic test_pad_r();
        for (int i = 0; i < SETTLE_N; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd2, 1'b1, 1'b0, 8'd247, 8'd240}) begin
                errors++;
                $display("FAIL pad_r_settle i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd2, 1'b1, 1'b0, 8'd247, 8'd240});
            end
            paddle_r_y = 8'd3;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd2, 1'b0, 1'b0, 8'd247, 8'(240 + i)}) begin
                errors++;
                $display("FAIL pad_r_draw i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd2, 1'b0, 1'b0, 8'd247, 8'(240 + i)});
            end
        end
    endtask

    task automatic test_ball();
        logic [7:0] ex, ey;
        for (int i = 0; i < SETTLE_N; i++) begin
            tick();
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd3, 1'b1, 1'b0, 8'd50, 8'd60}) begin
                errors++;
                $display("FAIL ball_settle i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd3, 1'b1, 1'b0, 8'd50, 8'd60});
            end
        end
        for (int i = 0; i < BALL_N; i++) begin
            tick();
`ifdef XY_SCAN_BALL_CROSS_EN
            case (i % 5)
                0:       begin ex = 8'd50; ey = 8'd60; end
                1:       begin ex = 8'd52; ey = 8'd60; end
                2:       begin ex = 8'd48; ey = 8'd60; end
                3:       begin ex = 8'd50; ey = 8'd62; end
                default: begin ex = 8'd50; ey = 8'd58; end
            endcase
`else
            ex = 8'd50;
            ey = 8'd60;
`endif
            checks++;
            if ({src, blank, frame_tick, x_out, y_out} !== {2'd3, 1'b0, 1'b0, ex, ey}) begin
                errors++;
                $display("FAIL ball_draw i=%0d got=%h exp=%h", i, {src, blank, frame_tick, x_out, y_out},
                         {2'd3, 1'b0, 1'b0, ex, ey});
            end
            if (i == 10) ball_x = 8'd70;
        end
    endtask

    task automatic test_frame_period();
        paddle_l_y = 8'd255;
        paddle_r_y = 8'd0;
        tick();
        checks++;
        if ({src, blank, frame_tick} !== {2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL frame_restart got=%b exp=%b", {src, blank, frame_tick}, {2'd0, 1'b1, 1'b1});
        end
        checks++;
        if (last_tick - prev_tick != FRAME) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", last_tick - prev_tick, FRAME);
        end
    endtask

    task automatic test_pad_top_edge();
        int n = 0;
        do begin
            tick();
            n++;
        end while (src !== 2'd1 && n < 2000);
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd1, 1'b1, 1'b0, 8'd8, 8'd255}) begin
            errors++;
            $display("FAIL pad255_settle got=%h exp=%h after %0d cycles", {src, blank, frame_tick, x_out, y_out},
                     {2'd1, 1'b1, 1'b0, 8'd8, 8'd255}, n);
        end
        repeat (SETTLE_N - 1) tick();
        tick();
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd1, 1'b0, 1'b0, 8'd8, 8'd255}) begin
            errors++;
            $display("FAIL pad255_draw got=%h exp=%h", {src, blank, frame_tick, x_out, y_out},
                     {2'd1, 1'b0, 1'b0, 8'd8, 8'd255});
        end
        tick();
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd2, 1'b1, 1'b0, 8'd247, 8'd0}) begin
            errors++;
            $display("FAIL pad255_exit got=%h exp=%h", {src, blank, frame_tick, x_out, y_out},
                     {2'd2, 1'b1, 1'b0, 8'd247, 8'd0});
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(src === 2'd2 && blank === 1'b0) && n < 100);
        checks++;
        if ({src, blank} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reach_pad_r_draw got=%b exp=%b", {src, blank}, {2'd2, 1'b0});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({src, blank, frame_tick, x_out, y_out} !== {2'd0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", {src, blank, frame_tick, x_out, y_out},
                     {2'd0, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({src, blank, frame_tick} !== {2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_restart got=%b exp=%b", {src, blank, frame_tick}, {2'd0, 1'b1, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_border();
        test_pad_l();
        test_pad_r();
        test_ball();
        test_frame_period();
        test_pad_top_edge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
